// File: rtl/phase_measure_pkg.sv
// phase_measure_pkg
//   Shared constants for the phase_measure_multi peripheral: Avalon word
//   offsets of the register file, CTRL/STATUS bit positions and the
//   measurement FSM state encoding.
package phase_measure_pkg;

  // Register word offsets. PHASE_SUM[k] lives at REG_PHASE_BASE + k, k >= 1,
  // so PHASE_SUM[1] directly follows PERIOD_SUM.
  localparam int REG_CTRL       = 0;
  localparam int REG_STATUS     = 1;
  localparam int REG_PERIOD     = 2;
  localparam int REG_PHASE_BASE = 2;

  // CTRL bits (START and ABORT are strobes, IRQ_EN is held)
  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_ABORT  = 2;

  // STATUS bits. MISS[k] sits at STAT_MISS_BASE + k - 1.
  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_TIMEOUT   = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_MISS_BASE = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } state_t;

endpackage

// File: rtl/phase_measure_multi_edge_sync.sv
// edge_sync
//   SYNC_STAGES-flop synchroniser followed by a rising-edge detector.
//   Latency from an input rise to the pulse is SYNC_STAGES+1 clocks and is
//   the same for every instance, so relative timing between channels is kept.
// Ports:
//   clk    - sampling clock
//   rst_n  - asynchronous active-low reset
//   d      - asynchronous input
//   pulse  - one-cycle pulse, registered, the cycle after the synchronised
//            level rises
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d};
      level_q <= sync_q[SYNC_STAGES-1];
      pulse   <= sync_q[SYNC_STAGES-1] & ~level_q;
    end
  end

endmodule

// File: rtl/phase_measure_multi.sv
// phase_measure_multi
//   Multi-channel period and phase-difference meter with an Avalon-MM slave.
//   Channel 0 of coe_S_in is the reference. After START the block waits for a
//   reference edge, then over 2^AVG_LOG2 reference periods sums the period
//   length and, per channel k, the delay from each reference edge to the
//   first channel-k edge of that period.
//
//   Avalon handshake: single-cycle slave with zero wait states. A write takes
//   effect on the clock edge that samples chipselect&write; read data is a
//   combinational function of the address while chipselect&read is high, and
//   reads have no side effects.
//
// Ports:
//   csi_clk, csi_reset_n        - clock, asynchronous active-low reset
//   avs_chipselect/address/read/write/writedata/readdata - register slave
//   coe_S_in[CH-1:0]            - asynchronous inputs, bit 0 = reference
//   ins_irq                     - level interrupt IRQ_EN & (DONE | TIMEOUT)
//   dbg_state                   - current FSM state (phase_measure_pkg::state_t)
module phase_measure_multi
  import phase_measure_pkg::*;
#(
  parameter int CH          = 3,
  parameter int CNT_W       = 32,
  parameter int AVG_LOG2    = 0,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 50_000_000
) (
  input  logic                      csi_clk,
  input  logic                      csi_reset_n,
  input  logic                      avs_chipselect,
  input  logic [$clog2(CH+2)-1:0]   avs_address,
  input  logic                      avs_read,
  input  logic                      avs_write,
  input  logic [31:0]               avs_writedata,
  output logic [31:0]               avs_readdata,
  input  logic [CH-1:0]             coe_S_in,
  output logic                      ins_irq,
  output logic [1:0]                dbg_state
);

  localparam int AW    = $clog2(CH+2);
  localparam int TO_W  = $clog2(TIMEOUT+1);
  localparam int IDX_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((1 << AVG_LOG2) - 1);

  state_t                      state;
  logic                        irq_en;
  logic                        done;
  logic                        timeout_f;
  logic                        ovf;
  logic [CH-1:1]               miss;
  logic [CH-1:1]               seen;
  logic [CNT_W-1:0]            period_acc;
  logic [CH-1:1][CNT_W-1:0]    phase_acc;
  logic [CNT_W-1:0]            period_sum;
  logic [CH-1:1][CNT_W-1:0]    phase_sum;
  logic [IDX_W-1:0]            period_idx;
  logic [TO_W-1:0]             to_cnt;

  logic [CH-1:0]               pulse;
  logic                        ref_pulse;
  logic [CH-1:1]               ch_pulse;

  // ---------------------------------------------------------------------
  // Input synchronisers and edge detectors
  // ---------------------------------------------------------------------
  genvar g;
  generate
    for (g = 0; g < CH; g++) begin : g_sync
      edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (csi_clk),
        .rst_n (csi_reset_n),
        .d     (coe_S_in[g]),
        .pulse (pulse[g])
      );
    end
  endgenerate

  assign ref_pulse = pulse[0];
  assign ch_pulse  = pulse[CH-1:1];

  // ---------------------------------------------------------------------
  // Bus write decode
  // ---------------------------------------------------------------------
  logic wr_en;
  logic ctrl_wr;
  logic status_wr;
  logic start_req;
  logic abort_req;
  logic unused_wdata;

  assign wr_en     = avs_chipselect & avs_write;
  assign ctrl_wr   = wr_en && (avs_address == AW'(REG_CTRL));
  assign status_wr = wr_en && (avs_address == AW'(REG_STATUS));
  assign start_req = ctrl_wr & avs_writedata[CTRL_START];
  assign abort_req = ctrl_wr & avs_writedata[CTRL_ABORT];
  assign unused_wdata = ^avs_writedata[31:4];

  // ---------------------------------------------------------------------
  // Next accumulator values for the current cycle.
  // A reference-edge cycle already belongs to the new period, so on such a
  // cycle every channel counts unless its own edge arrives together with
  // the reference (phase 0). Inside a period a channel counts until its
  // first edge.
  // ---------------------------------------------------------------------
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0]         period_nxt;
  logic [CH-1:1][CNT_W-1:0] phase_nxt;
  logic [CH-1:1]            phase_inc;
  logic                     ovf_hit;

  always_comb begin
    period_nxt = sat_inc(period_acc);
    ovf_hit    = (period_nxt == CNT_MAX);
    phase_nxt  = phase_acc;
    phase_inc  = '0;
    for (int k = 1; k < CH; k++) begin
      phase_inc[k] = ~ch_pulse[k] & (ref_pulse | ~seen[k]);
      if (phase_inc[k]) begin
        phase_nxt[k] = sat_inc(phase_acc[k]);
        if (phase_nxt[k] == CNT_MAX) ovf_hit = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM, accumulators, timeout and flags
  // ---------------------------------------------------------------------
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      state      <= ST_IDLE;
      irq_en     <= 1'b0;
      done       <= 1'b0;
      timeout_f  <= 1'b0;
      ovf        <= 1'b0;
      miss       <= '0;
      seen       <= '0;
      period_acc <= '0;
      phase_acc  <= '0;
      period_sum <= '0;
      phase_sum  <= '0;
      period_idx <= '0;
      to_cnt     <= '0;
    end else begin
      if (ctrl_wr) irq_en <= avs_writedata[CTRL_IRQ_EN];

      // Clears first; any hardware set below overrides them in the same cycle.
      if (status_wr) begin
        if (avs_writedata[STAT_DONE])    done      <= 1'b0;
        if (avs_writedata[STAT_TIMEOUT]) timeout_f <= 1'b0;
        if (avs_writedata[STAT_OVF])     ovf       <= 1'b0;
      end

      if (abort_req) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_req) begin
              state      <= ST_ARM;
              period_acc <= '0;
              phase_acc  <= '0;
              seen       <= '0;
              period_idx <= '0;
              to_cnt     <= '0;
              done       <= 1'b0;
              timeout_f  <= 1'b0;
              ovf        <= 1'b0;
              miss       <= '0;
            end
          end

          ST_ARM: begin
            if (ref_pulse) begin
              state      <= ST_MEAS;
              period_acc <= period_nxt;
              phase_acc  <= phase_nxt;
              seen       <= ch_pulse;
              to_cnt     <= '0;
              if (ovf_hit) ovf <= 1'b1;
            end else if (to_cnt == TO_LAST) begin
              timeout_f <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end

          ST_MEAS: begin
            if (ref_pulse) begin
              // MISS uses seen from before this edge; a coincident channel
              // edge belongs to the new period.
              miss   <= miss | ~seen;
              to_cnt <= '0;
              if (period_idx == LAST_IDX) begin
                period_sum <= period_acc;
                phase_sum  <= phase_acc;
                done       <= 1'b1;
                state      <= ST_IDLE;
              end else begin
                period_idx <= period_idx + IDX_W'(1);
                period_acc <= period_nxt;
                phase_acc  <= phase_nxt;
                seen       <= ch_pulse;
                if (ovf_hit) ovf <= 1'b1;
              end
            end else begin
              period_acc <= period_nxt;
              phase_acc  <= phase_nxt;
              seen       <= seen | ch_pulse;
              if (ovf_hit) ovf <= 1'b1;
              if (to_cnt == TO_LAST) begin
                timeout_f <= 1'b1;
                state     <= ST_IDLE;
              end else begin
                to_cnt <= to_cnt + TO_W'(1);
              end
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read mux and outputs
  // ---------------------------------------------------------------------
  logic busy;
  assign busy = (state != ST_IDLE);

  always_comb begin
    avs_readdata = '0;
    if (avs_chipselect && avs_read) begin
      if (avs_address == AW'(REG_CTRL)) begin
        avs_readdata[CTRL_IRQ_EN] = irq_en;
      end else if (avs_address == AW'(REG_STATUS)) begin
        avs_readdata[STAT_BUSY]    = busy;
        avs_readdata[STAT_DONE]    = done;
        avs_readdata[STAT_TIMEOUT] = timeout_f;
        avs_readdata[STAT_OVF]     = ovf;
        for (int k = 1; k < CH; k++) begin
          avs_readdata[STAT_MISS_BASE + k - 1] = miss[k];
        end
      end else if (avs_address == AW'(REG_PERIOD)) begin
        avs_readdata = 32'(period_sum);
      end else begin
        for (int k = 1; k < CH; k++) begin
          if (avs_address == AW'(REG_PHASE_BASE + k)) avs_readdata = 32'(phase_sum[k]);
        end
      end
    end
  end

  assign ins_irq   = irq_en & (done | timeout_f);
  assign dbg_state = state;

endmodule

// File: tb/tb_phase_measure_multi.sv
// tb_phase_measure_multi
//   Two instances: dut_a (CNT_W=32, 4 periods averaged) and dut_b (CNT_W=8,
//   single period). A shared waveform generator drives a reference and two
//   channels with a programmable period, per-channel delay and enable.
//   Expected sums come from the waveform parameters: period*N, delay*N for a
//   running channel, period*N plus MISS for a silent one, clipped at the
//   accumulator maximum with OVF.
module tb_phase_measure_multi;
  localparam int CH = 3;
  localparam int AW = $clog2(CH+2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          cs_a, cs_b, rd_en, wr_en;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata_a, rdata_b;
  logic          irq_a, irq_b;
  logic [1:0]    st_a, st_b;
  logic [CH-1:0] s_in;

  int n_cmp = 0;
  int n_err = 0;

  phase_measure_multi #(.CH(CH), .CNT_W(32), .AVG_LOG2(2), .SYNC_STAGES(2), .TIMEOUT(1000)) dut_a (
    .csi_clk(clk), .csi_reset_n(rst_n), .avs_chipselect(cs_a), .avs_address(addr),
    .avs_read(rd_en), .avs_write(wr_en), .avs_writedata(wdata), .avs_readdata(rdata_a),
    .coe_S_in(s_in), .ins_irq(irq_a), .dbg_state(st_a));

  phase_measure_multi #(.CH(CH), .CNT_W(8), .AVG_LOG2(0), .SYNC_STAGES(2), .TIMEOUT(1000)) dut_b (
    .csi_clk(clk), .csi_reset_n(rst_n), .avs_chipselect(cs_b), .avs_address(addr),
    .avs_read(rd_en), .avs_write(wr_en), .avs_writedata(wdata), .avs_readdata(rdata_b),
    .coe_S_in(s_in), .ins_irq(irq_b), .dbg_state(st_b));

  // ---------------- waveform generator ----------------
  int gen_p = 100;
  int gen_off [CH];
  bit gen_en  [CH];
  bit gen_on  = 1'b0;
  int gen_cyc = 0;

  always @(negedge clk) begin : gen_blk
    logic [CH-1:0] v;
    v = '0;
    if (gen_on) begin
      v[0] = (gen_cyc % gen_p) < (gen_p / 2);
      for (int k = 1; k < CH; k++) begin
        if (gen_en[k] && gen_cyc >= gen_off[k])
          v[k] = ((gen_cyc - gen_off[k]) % gen_p) < (gen_p / 2);
      end
      gen_cyc = gen_cyc + 1;
    end else begin
      gen_cyc = 0;
    end
    s_in = v;
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input bit sel_b, input int a, input logic [31:0] d);
    @(negedge clk);
    cs_a = !sel_b; cs_b = sel_b; wr_en = 1'b1; addr = AW'(a); wdata = d;
    @(negedge clk);
    cs_a = 1'b0; cs_b = 1'b0; wr_en = 1'b0; wdata = '0;
  endtask

  task automatic bus_rd(input bit sel_b, input int a, output logic [31:0] d);
    @(negedge clk);
    cs_a = !sel_b; cs_b = sel_b; rd_en = 1'b1; addr = AW'(a);
    #1;
    d = sel_b ? rdata_b : rdata_a;
    cs_a = 1'b0; cs_b = 1'b0; rd_en = 1'b0;
  endtask

  task automatic rd_check(input bit sel_b, input int a, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    bus_rd(sel_b, a, d);
    check_eq(tag, d, exp);
  endtask

  task automatic set_wave(input int p, input int off1, input bit en1, input int off2, input bit en2);
    gen_on = 1'b0;
    repeat (6) @(negedge clk);
    gen_p = p;
    gen_off[1] = off1; gen_en[1] = en1;
    gen_off[2] = off2; gen_en[2] = en2;
    gen_on = 1'b1;
  endtask

  task automatic wait_idle(input bit sel_b, input int budget, input string tag);
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      repeat (8) @(posedge clk);
      bus_rd(sel_b, 1, s);
      n += 9;
    end while (s[0] && n < budget);
    check_eq({tag, "_idle"}, 32'(s[0]), 32'd0);
  endtask

  task automatic wait_meas(input bit sel_b, input int budget, input string tag);
    logic [1:0] st;
    st = 2'd0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      st = sel_b ? st_b : st_a;
      if (st == 2'd2) break;
    end
    check_eq({tag, "_meas"}, 32'(st), 32'd2);
  endtask

  // Reference model: sums derived from the generated waveform.
  task automatic check_run(input bit sel_b, input int n_per, input int cnt_w, input string tag);
    longint mx, tot;
    logic [31:0] e_stat;
    mx = (64'd1 << cnt_w) - 1;
    e_stat = 32'h2;
    tot = longint'(gen_p) * n_per;
    if (tot >= mx) begin tot = mx; e_stat[3] = 1'b1; end
    rd_check(sel_b, 2, 32'(tot), {tag, "_period"});
    for (int k = 1; k < CH; k++) begin
      tot = longint'(gen_en[k] ? gen_off[k] : gen_p) * n_per;
      if (!gen_en[k]) e_stat[8 + k - 1] = 1'b1;
      if (tot >= mx) begin tot = mx; e_stat[3] = 1'b1; end
      rd_check(sel_b, 2 + k, 32'(tot), $sformatf("%s_phase%0d", tag, k));
    end
    rd_check(sel_b, 1, e_stat, {tag, "_status"});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int p, o1, o2;
    bit e1, e2;
    cs_a = 0; cs_b = 0; rd_en = 0; wr_en = 0; addr = '0; wdata = '0;
    gen_off[0] = 0; gen_en[0] = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    #1;
    check_eq("rst_rdata_idle", rdata_a, 32'd0);
    check_eq("rst_irq", 32'(irq_a), 32'd0);
    check_eq("rst_state", 32'(st_a), 32'd0);
    for (int a = 0; a < 8; a++) rd_check(1'b0, a, 32'd0, $sformatf("rst_reg%0d", a));
    rd_check(1'b1, 1, 32'd0, "rst_b_status");

    // directed: period 100, ch1 +25, ch2 in phase, IRQ enabled
    set_wave(100, 25, 1'b1, 0, 1'b1);
    bus_wr(1'b0, 0, 32'h3);
    wait_idle(1'b0, 1500, "t1");
    check_run(1'b0, 4, 32, "t1");
    check_eq("t1_irq", 32'(irq_a), 32'd1);
    rd_check(1'b0, 0, 32'h2, "t1_ctrl");
    bus_wr(1'b0, 1, 32'h2);
    check_eq("t1_irq_clr", 32'(irq_a), 32'd0);

    // randomized waveforms
    for (int r = 0; r < 5; r++) begin
      p  = $urandom_range(20, 120);
      o1 = $urandom_range(0, p - 1);
      o2 = $urandom_range(0, p - 1);
      e1 = ($urandom_range(0, 3) != 0);
      e2 = ($urandom_range(0, 3) != 0);
      set_wave(p, o1, e1, o2, e2);
      bus_wr(1'b0, 0, 32'h3);
      wait_idle(1'b0, 6 * p + 200, $sformatf("rnd%0d", r));
      check_run(1'b0, 4, 32, $sformatf("rnd%0d", r));
      check_eq($sformatf("rnd%0d_irq", r), 32'(irq_a), 32'd1);
      bus_wr(1'b0, 1, 32'h2);
    end

    // ch2 held low, period 50
    set_wave(50, 10, 1'b1, 0, 1'b0);
    bus_wr(1'b0, 0, 32'h3);
    wait_idle(1'b0, 800, "miss");
    check_run(1'b0, 4, 32, "miss");

    // timeout: no reference edges
    gen_on = 1'b0;
    bus_wr(1'b0, 0, 32'h3);
    repeat (900) @(posedge clk);
    rd_check(1'b0, 1, 32'h1, "to_early_status");
    repeat (200) @(posedge clk);
    rd_check(1'b0, 1, 32'h4, "to_status");
    rd_check(1'b0, 2, 32'd200, "to_period_kept");
    check_eq("to_irq", 32'(irq_a), 32'd1);
    bus_wr(1'b0, 1, 32'h4);
    check_eq("to_irq_clr", 32'(irq_a), 32'd0);
    rd_check(1'b0, 1, 32'h0, "to_status_clr");

    // abort mid-MEAS on dut_b, then a clean run
    set_wave(80, 30, 1'b1, 0, 1'b1);
    bus_wr(1'b1, 0, 32'h1);
    wait_meas(1'b1, 400, "ab");
    repeat (20) @(posedge clk);
    bus_wr(1'b1, 0, 32'h4);
    rd_check(1'b1, 1, 32'h0, "ab_status");
    rd_check(1'b1, 2, 32'h0, "ab_period");
    bus_wr(1'b1, 0, 32'h1);
    wait_idle(1'b1, 400, "ab2");
    check_run(1'b1, 1, 8, "ab2");
    check_eq("ab2_irq_off", 32'(irq_b), 32'd0);

    // 8-bit saturation
    set_wave(300, 10, 1'b1, 0, 1'b0);
    bus_wr(1'b1, 0, 32'h1);
    wait_idle(1'b1, 1200, "ovf");
    check_run(1'b1, 1, 8, "ovf");

    // reset mid-MEAS, then a correct measurement
    set_wave(100, 40, 1'b1, 70, 1'b1);
    bus_wr(1'b0, 0, 32'h3);
    wait_meas(1'b0, 400, "rm");
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rm_state", 32'(st_a), 32'd0);
    check_eq("rm_irq", 32'(irq_a), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 5; a++) rd_check(1'b0, a, 32'd0, $sformatf("rm_reg%0d", a));
    bus_wr(1'b0, 0, 32'h3);
    wait_idle(1'b0, 800, "rm2");
    check_run(1'b0, 4, 32, "rm2");
    check_eq("rm2_irq", 32'(irq_a), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/phase_measure_multi.md
# phase_measure_multi

Parametrised multi-channel period and phase-difference meter with an Avalon-MM slave, for the SOPC peripheral set. One reference input (channel 0) and up to eight further inputs are synchronised into `csi_clk`. Over 2^AVG_LOG2 reference periods the block accumulates:
- the total period count;
- per channel, the delay from each reference rising edge to that channel's first rising edge.

Software starts a measurement, polls STATUS or takes `ins_irq`, then reads the sums.

## Interface
- CH, 3: number of inputs including the reference; legal range 2..9.
- CNT_W, 32: width of the period and phase accumulators; legal range 8..32.
- AVG_LOG2, 0: log2 of the number of reference periods averaged; legal range 0..8.
- SYNC_STAGES, 2: synchroniser depth per input; minimum 2.
- TIMEOUT, 50_000_000: maximum number of `csi_clk` cycles allowed between reference edges.
- csi_clk in 1: the block's only clock; all logic is on its rising edge.
- csi_reset_n in 1: reset; asynchronous assert, active-low.
- avs_chipselect in 1: slave select.
- avs_address in clog2(CH+2): word address.
- avs_read in 1: read strobe.
- avs_write in 1: write strobe.
- avs_writedata in 32: write data.
- avs_readdata out 32: read data; combinational, zero wait states; 0 when not (chipselect & read).
- coe_S_in in CH: asynchronous measured signals; bit 0 is the reference.
- ins_irq out 1: level interrupt.

## Operation
**Register map (word addresses)**
- 0 CTRL.
  - Write: bit0 START (self-clearing), bit1 IRQ_EN (held), bit2 ABORT (self-clearing).
  - Read: bit1 = IRQ_EN; all other bits 0.
- 1 STATUS.
  - bit0 BUSY.
  - bit1 DONE: write-1-to-clear.
  - bit2 TIMEOUT: write-1-to-clear.
  - bit3 OVF: write-1-to-clear.
  - bits[8+k-1] MISS[k] for k = 1..CH-1.
- 2 PERIOD_SUM: zero-extended to 32 bits.
- 2+k PHASE_SUM[k] for k = 1..CH-1.
- Addresses above 2+CH-1 read 0.

**FSM: IDLE → ARM → MEAS → IDLE**
- IDLE → ARM on START.
  - Clears all accumulators and the DONE, TIMEOUT, OVF and MISS flags.
  - BUSY = 1.
- ARM → MEAS on the first reference edge pulse.
  - Period counter and per-channel timers start at that edge.
- In MEAS, each cycle:
  - The period accumulator increments.
  - Each channel k with its "seen" bit clear increments its phase accumulator.
  - A channel-k edge pulse sets seen[k]. Any later edge of channel k in the same period is ignored.
- On each reference edge pulse in MEAS:
  - The period index increments.
  - Every channel with seen = 0 sets MISS[k]; its partial count for that period stays in the sum.
  - All seen bits clear.
- After the 2^AVG_LOG2-th reference edge: result registers load, DONE = 1, BUSY = 0, state → IDLE.
- In ARM or MEAS, if TIMEOUT cycles pass with no reference edge: TIMEOUT = 1, BUSY = 0, state → IDLE, result registers unchanged.
- ABORT in any state: → IDLE, BUSY = 0, result registers unchanged, no DONE.
- START while BUSY is ignored.
- `ins_irq` = IRQ_EN & (DONE | TIMEOUT).

**Boundaries**
- Channel edge in the same cycle as a reference edge: counts as phase 0 for the new period. The closing period's MISS check uses the seen value from before that edge.
- Accumulator reaching all-ones saturates there and sets OVF.
- A CPU write-1-to-clear in the same cycle that the hardware sets the flag: set wins.
- Reset asserted mid-measurement: immediate return to IDLE with everything zeroed.

## Timing
- Reset values:
  - avs_readdata 0, ins_irq 0.
  - All registers, flags and IRQ_EN 0.
  - State IDLE.
- Input to edge-pulse latency is SYNC_STAGES+1 cycles, identical on every channel, so measured phase is unaffected.
- Edge pulse is one cycle wide, asserted the cycle after the synchronised level rises.
- START write at cycle t: BUSY readable at t+1.
- Final reference edge pulse at cycle t: results and DONE visible at t+1.
- The write-1-to-clear and START side effects take effect on the clock edge that samples the write.

## Structure
- Package `phase_measure_pkg`:
  - register word offsets;
  - STATUS and CTRL bit positions;
  - FSM state encoding (IDLE, ARM, MEAS).
- Sub-module `edge_sync`: SYNC_STAGES-flop synchroniser plus rising-edge detector. It is instantiated CH times via generate.
- Top level holds the FSM, accumulators, timeout counter and register file.

## Test plan
- CH=3, AVG_LOG2=2, reference period 100 clk, ch1 lagging by 25 clk, ch2 in phase → PERIOD_SUM=400, PHASE_SUM[1]=100, PHASE_SUM[2]=0, DONE=1, MISS=0, irq high when IRQ_EN=1.
- TIMEOUT=1000, no reference edges after START → TIMEOUT=1 after 1000 cycles, BUSY=0, results unchanged; write 0x4 to STATUS → irq drops.
- ch2 held low, reference period 50 → MISS[2]=1, PHASE_SUM[2]=50·2^AVG_LOG2, PERIOD_SUM correct.
- ABORT mid-MEAS, then START with reference period 80 and AVG_LOG2=0 → first run leaves no DONE; second run gives PERIOD_SUM=80.
- CNT_W=8, reference period 300 → PERIOD_SUM=255, OVF=1.
- csi_reset_n pulsed low mid-MEAS → all readbacks 0, state IDLE; a subsequent START measures correctly.
